// File: rtl/game_core_ctrl.sv
// game_core_ctrl: screen state machine plus N-channel modulo counter bank with wrap flags and alarm timer.
module game_core_ctrl #(
  parameter int N_CH      = 10,
  parameter int CW        = 4,
  parameter int MODULUS   = 10,
  parameter int INIT_VAL  = 1,
  parameter int ALARM_LEN = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_help,
  input  logic               key_start,
  input  logic               key_back,
  input  logic               key_count,
  input  logic               key_confirm,
  input  logic               key_quit,
  input  logic               key_up,
  input  logic               key_down,
  input  logic               key_left,
  input  logic               key_right,
  output logic [2:0]         state,
  output logic [4:0]         active_num,
  output logic [3:0]         cursor,
  output logic [N_CH*CW-1:0] counters,
  output logic [N_CH-1:0]    wrap_flags,
  output logic               alarm,
  output logic               game_over
);
  localparam int TW = $clog2(ALARM_LEN + 1);
  localparam logic [2:0] S_START = 3'd0, S_HELP = 3'd1, S_SELECT = 3'd2, S_PLAY = 3'd3, S_OVER = 3'd4;
  logic [2:0]         nxt_state;
  logic [N_CH*CW-1:0] nxt_cnt;
  logic [N_CH-1:0]    nxt_flags, act_mask;
  logic [TW-1:0]      timer;
  logic               wrap, all_done, clear;
  function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
    return (v == CW'(MODULUS - 1)) ? '0 : v + 1'b1;
  endfunction
  always_comb begin
    nxt_cnt = counters;
    nxt_flags = wrap_flags;
    wrap = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      act_mask[i] = i < int'(active_num);
      if (state == S_PLAY && !key_quit && act_mask[i] &&
          (key_confirm || ((key_up || key_down) && i == int'(cursor)))) begin
        if (key_confirm || key_up) begin
          nxt_cnt[i*CW +: CW] = inc(counters[i*CW +: CW]);
          if (counters[i*CW +: CW] == CW'(MODULUS - 1)) begin
            nxt_flags[i] = 1'b1;
            wrap = 1'b1;
          end
        end else
          nxt_cnt[i*CW +: CW] = (counters[i*CW +: CW] == '0) ? CW'(MODULUS - 1) : counters[i*CW +: CW] - 1'b1;
      end
    end
  end
  assign all_done = &(nxt_flags | ~act_mask);
  always_ff @(posedge clk)
    state <= rst ? S_START : nxt_state;
  always_comb begin
    nxt_state = state;
    case (state)
      S_START:  nxt_state = key_help ? S_HELP : key_start ? S_SELECT : S_START;
      S_HELP:   nxt_state = key_back ? S_START : key_start ? S_SELECT : S_HELP;
      S_SELECT: nxt_state = key_back ? S_START : key_confirm ? S_PLAY : S_SELECT;
      S_PLAY:   nxt_state = key_quit ? S_START : all_done ? S_OVER : S_PLAY;
      S_OVER:   nxt_state = key_back ? S_START : S_OVER;
      default:  nxt_state = S_START;
    endcase
  end
  always_comb begin
    game_over = state == S_OVER;
    alarm = timer != '0;
  end
  // quit in PLAY and back in OVER share the clearing path with reset, except active_num
  assign clear = (state == S_PLAY && key_quit) || (state == S_OVER && key_back);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      counters <= '0;
      wrap_flags <= '0;
      cursor <= '0;
      timer <= '0;
      if (rst) active_num <= 5'd1;
    end else begin
      counters <= nxt_cnt;
      wrap_flags <= nxt_flags;
      timer <= wrap ? TW'(ALARM_LEN) : alarm ? timer - 1'b1 : timer;
      if (state == S_SELECT && !key_back) begin
        if (key_confirm) begin
          for (int i = 0; i < N_CH; i++)
            counters[i*CW +: CW] <= act_mask[i] ? CW'(INIT_VAL) : '0;
          cursor <= '0;
          wrap_flags <= '0;
        end else if (key_count)
          active_num <= (active_num == 5'(N_CH)) ? 5'd1 : active_num + 5'd1;
      end
      if (state == S_PLAY && !key_confirm && !key_up && !key_down)
        cursor <= key_right ? (({1'b0, cursor} == active_num - 5'd1) ? '0 : cursor + 4'd1) :
                  key_left  ? ((cursor == '0) ? 4'(active_num - 5'd1) : cursor - 4'd1) : cursor;
    end
  end
endmodule

// File: tb/tb_game_core_ctrl.sv
// tb_game_core_ctrl: directed checks of screen flow, counters, wrap flags and alarm timing.
module tb_game_core_ctrl;
  localparam int N_CH = 10, CW = 4, ALARM_LEN = 8;
  localparam int HELP = 0, START = 1, BACK = 2, COUNT = 3, CONFIRM = 4, QUIT = 5, UP = 6, DOWN = 7, LEFT = 8, RIGHT = 9;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] keys = '0;
  logic [2:0] state;
  logic [4:0] active_num;
  logic [3:0] cursor;
  logic [N_CH*CW-1:0] counters;
  logic [N_CH-1:0] wrap_flags;
  logic alarm, game_over;
  int n_chk = 0, n_fail = 0, n_high;
  always #5 clk = ~clk;
  game_core_ctrl #(.N_CH(N_CH), .CW(CW), .MODULUS(10), .INIT_VAL(1), .ALARM_LEN(ALARM_LEN)) dut (
    .clk(clk), .rst(rst),
    .key_help(keys[HELP]), .key_start(keys[START]), .key_back(keys[BACK]), .key_count(keys[COUNT]),
    .key_confirm(keys[CONFIRM]), .key_quit(keys[QUIT]), .key_up(keys[UP]), .key_down(keys[DOWN]),
    .key_left(keys[LEFT]), .key_right(keys[RIGHT]),
    .state(state), .active_num(active_num), .cursor(cursor), .counters(counters),
    .wrap_flags(wrap_flags), .alarm(alarm), .game_over(game_over));
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic press(input logic [9:0] k);
    @(negedge clk);
    keys = k;
    @(negedge clk);
    keys = '0;
  endtask
  task automatic check_reset(input string tag);
    check({tag, " state"}, 64'(state), 0);
    check({tag, " active_num"}, 64'(active_num), 1);
    check({tag, " cursor"}, 64'(cursor), 0);
    check({tag, " counters"}, 64'(counters), 0);
    check({tag, " flags"}, 64'(wrap_flags), 0);
    check({tag, " alarm"}, 64'(alarm), 0);
    check({tag, " game_over"}, 64'(game_over), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset("reset");
    press(10'(1) << START);
    check("to_select", 64'(state), 2);
    repeat (11) press(10'(1) << COUNT);
    check("count11", 64'(active_num), 2);
    press(10'(1) << CONFIRM);
    check("play_state", 64'(state), 3);
    check("play_load", 64'(counters), 64'h11);
    press(10'(1) << UP);
    check("up_ch0", 64'(counters), 64'h12);
    press(10'(1) << RIGHT);
    check("right", 64'(cursor), 1);
    press(10'(1) << LEFT);
    press(10'(1) << LEFT);
    check("left_wrap2", 64'(cursor), 1);
    press(10'(1) << RIGHT);
    check("right_wrap2", 64'(cursor), 0);
    repeat (3) press(10'(1) << DOWN);
    check("down_0_to_9", 64'(counters), 64'h19);
    check("down_no_flag", 64'(wrap_flags), 0);
    check("down_no_alarm", 64'(alarm), 0);
    press(10'(1) << UP);
    check("up_wrap_cnt", 64'(counters), 64'h10);
    check("up_wrap_flag", 64'(wrap_flags), 1);
    check("still_play", 64'(state), 3);
    n_high = 0;
    for (int i = 0; i < 20; i++) begin
      if (alarm) n_high++;
      @(negedge clk);
    end
    check("alarm_len", 64'(n_high), ALARM_LEN);
    press(10'(1) << RIGHT);
    repeat (8) press(10'(1) << UP);
    press(10'(1) << LEFT);
    press(10'(1) << DOWN);
    check("both_nine", 64'(counters), 64'h99);
    check("flag_kept", 64'(wrap_flags), 1);
    press(10'(1) << CONFIRM);
    check("over_cnt", 64'(counters), 64'h00);
    check("over_flags", 64'(wrap_flags), 3);
    check("over_state", 64'(state), 4);
    check("over_go", 64'(game_over), 1);
    check("over_alarm", 64'(alarm), 1);
    press(10'(1) << CONFIRM);
    check("over_frozen", 64'(counters), 64'h00);
    press(10'(1) << BACK);
    check("back_state", 64'(state), 0);
    check("back_flags", 64'(wrap_flags), 0);
    check("back_alarm", 64'(alarm), 0);
    check("back_go", 64'(game_over), 0);
    press((10'(1) << HELP) | (10'(1) << START));
    check("help_wins", 64'(state), 1);
    press((10'(1) << BACK) | (10'(1) << START));
    check("back_wins_help", 64'(state), 0);
    press(10'(1) << HELP);
    press(10'(1) << START);
    check("help_to_select", 64'(state), 2);
    press((10'(1) << BACK) | (10'(1) << CONFIRM));
    check("back_wins_select", 64'(state), 0);
    press(10'(1) << START);
    press(10'(1) << COUNT);
    check("count3", 64'(active_num), 3);
    press(10'(1) << CONFIRM);
    check("load3", 64'(counters), 64'h111);
    press(10'(1) << LEFT);
    check("left3", 64'(cursor), 2);
    press(10'(1) << RIGHT);
    check("right3", 64'(cursor), 0);
    press((10'(1) << UP) | (10'(1) << DOWN));
    check("up_over_down", 64'(counters), 64'h112);
    press(10'(1) << CONFIRM);
    check("confirm_all", 64'(counters), 64'h223);
    press((10'(1) << QUIT) | (10'(1) << UP));
    check("quit_state", 64'(state), 0);
    check("quit_cnt", 64'(counters), 0);
    press(10'(1) << START);
    press(10'(1) << CONFIRM);
    repeat (2) press(10'(1) << DOWN);
    press(10'(1) << UP);
    check("pre_rst_alarm", 64'(alarm), 1);
    check("pre_rst_flags", 64'(wrap_flags), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midplay_rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
